ysyx_25010008_fetch_decode_exec: RTL and testbench
==================================================

# ysyx_25010008_fetch_decode_exec

Single-cycle RV32I+Zicsr front end and execute datapath: registered instruction fetch (IFU), combinational decode (IDU) and combinational execute/next-PC (EXU). It sits between the PC sequencer and the register file/LSU in the NPC core. The PC, GPR/CSR values and load data are external inputs.

## Interface
- No parameters.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- pc  in  32  address of the current instruction.
- fetch  in  1  capture the instruction at `pc` on this edge.
- imem_addr  out  32  equals `pc`; combinational read address.
- imem_rdata  in  32  word at `imem_addr`, same-cycle combinational.
- src1, src2  in  32  GPR values for rs1/rs2.
- csr_src  in  32  value of CSR `csr_s`.
- mem_rdata  in  32  load data, already extended by the LSU.
- inst  out  32  latched instruction.
- ivalid  out  1  `inst` is valid.
- rs1, rs2, rd  out  5  register indices `inst[19:15]`, `[24:20]`, `[11:7]`.
- r_wen  out  1  GPR write enable; forced 0 when rd=0.
- r_wdata  out  32  GPR write data.
- csr_s, csr_d1, csr_d2  out  12  CSR source and two destinations.
- csr_wen1, csr_wen2  out  1  CSR write enables.
- csr_wdata1, csr_wdata2  out  32  CSR write data.
- mem_ren, mem_wen  out  1  load and store strobes.
- suffix_b, suffix_h, sext  out  1  access size (byte/half; word otherwise) and sign-extension flag.
- alu_result  out  32  ALU output; this is the memory address for loads and stores.
- npc  out  32  next PC.
- halt  out  1  sticky stop flag.

## Operation
- **IFU:** on a clock edge with fetch=1: inst←imem_rdata, ivalid←1. ivalid stays 1 until the next fetch edge, then refreshes.
- **Enable gating:** when ivalid=0, every enable output is 0. This covers r_wen, csr_wen1/2, mem_ren/wen and the halt set condition.
- **Immediates:** I, S, B, U and J formats, all sign-extended.
- **ALU operations:** add, sub, sll, slt, sltu, xor, srl, sra, or, and.
- **ALU operand 2:** src2 for R-type and branches, imm otherwise.
- **Branch compare:** beq, bne, blt, bge, bltu, bgeu, computed from src1 vs src2.
- **r_wdata select:**
  - ALU result: OP, OP-IMM.
  - mem_rdata: loads.
  - pc+4: jal, jalr.
  - imm: lui.
  - pc+imm: auipc.
  - csr_src (old CSR value): csrrw, csrrs.
- **Loads:** lb/lh set sext=1; lbu/lhu set sext=0; lw has suffix_b=suffix_h=0.
- **Stores:** sb/sh/sw set mem_wen and the matching size flags.
- **npc:**
  - jal: pc+imm.
  - jalr: (src1+imm)&~1.
  - taken branch: pc+imm.
  - ecall, mret: csr_src.
  - otherwise: pc+4.
- **csrrw:** csr_s=csr_d1=inst[31:20], csr_wen1=1, csr_wdata1=src1.
- **csrrs:** csr_s=csr_d1=inst[31:20], csr_wen1=1, csr_wdata1=csr_src|src1.
- **ecall:**
  - csr_s=0x305 (mtvec).
  - csr_d1=0x341 (mepc), csr_wdata1=pc.
  - csr_d2=0x342 (mcause), csr_wdata2=11.
  - csr_wen1=csr_wen2=1.
- **mret:** csr_s=0x341; no writes.
- **Halt:** ebreak, or any unsupported encoding, sets halt on the next edge with no side effects. Halt stays 1 until rst.
- **Unused outputs:** unused CSR indices are 0 and unused data outputs are don't-care.

## Timing
- **Reset:** on rst assertion, immediately: inst=0, ivalid=0, halt=0. All gated enables are therefore 0.
- **Fetch latency:** one edge. Decode and execute outputs are valid combinationally in the cycle after the fetch edge.
- **fetch during reset:** ignored.
- **rst mid-instruction:** clears ivalid at once; no enable may glitch high afterwards.
- **Combinational paths:** npc, r_wdata, csr_wdata* and alu_result follow pc, src*, csr_src and mem_rdata within the same cycle. The LSU's one-cycle load delay is absorbed by the sequencer.

## Test plan
- **Reset then fetch:** reset; fetch addi x1,x0,5 (0x00500093) at pc=0x80000000 → next cycle: ivalid=1, rd=1, r_wen=1, r_wdata=5, npc=0x80000004.
- **Branches:** beq with src1=src2=7, imm=-8 → npc=pc-8. Same instruction with src2=8 → npc=pc+4.
- **Jump and upper immediates:**
  - jalr with src1=0x80000013, imm=0 → npc=0x80000012, r_wdata=pc+4.
  - lui 0x12345 → r_wdata=0x12345000.
  - auipc 1 → r_wdata=pc+0x1000.
- **Loads:** lbu with src1=0x80001000, imm=3 → alu_result=0x80001003, mem_ren=1, suffix_b=1, sext=0, r_wdata=mem_rdata.
- **CSR instructions:**
  - ecall at pc=0x80000010, csr_src=0x80000100 → npc=0x80000100, mepc write of 0x80000010, mcause write of 11.
  - csrrs with csr_src=0xF0, src1=0x0F → csr_wdata1=0xFF, r_wdata=0xF0.
- **Halt and async reset:** ebreak → halt=1 on the next edge and stays 1 through later fetches. Asserting rst between edges clears halt and ivalid immediately.

Source files
------------

// File: rtl/ysyx_25010008_fetch_decode_exec.sv
// Single-cycle RV32I+Zicsr fetch latch, decoder and execute/next-PC datapath.
// Unsupported encodings and ebreak raise a sticky halt with no side effects.
module ysyx_25010008_fetch_decode_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        fetch,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [31:0] csr_src,
   input  logic [31:0] mem_rdata,
   output logic [31:0] inst,
   output logic        ivalid,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        r_wen,
   output logic [31:0] r_wdata,
   output logic [11:0] csr_s,
   output logic [11:0] csr_d1,
   output logic [11:0] csr_d2,
   output logic        csr_wen1,
   output logic        csr_wen2,
   output logic [31:0] csr_wdata1,
   output logic [31:0] csr_wdata2,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic        suffix_b,
   output logic        suffix_h,
   output logic        sext,
   output logic [31:0] alu_result,
   output logic [31:0] npc,
   output logic        halt
);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_br;
   logic        is_ld, is_st, is_opi, is_op;
   logic        is_ecall, is_ebreak, is_mret, is_csrrw, is_csrrs;
   logic        legal, en, br_take;
   logic [31:0] op2;
   logic [4:0]  shamt;
   alu_op_e     alu_op;
   logic [31:0] pc4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst   <= '0;
         ivalid <= 1'b0;
      end else if (fetch) begin
         inst   <= imem_rdata;
         ivalid <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         halt <= 1'b0;
      else if (ivalid && !legal)
         halt <= 1'b1;
   end

   assign imem_addr = pc;
   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];
   assign rd  = inst[11:7];
   assign pc4 = pc + 32'd4;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};

   assign is_lui   = opc == 7'b0110111;
   assign is_auipc = opc == 7'b0010111;
   assign is_jal   = opc == 7'b1101111;
   assign is_jalr  = opc == 7'b1100111 && f3 == 3'b000;
   assign is_br    = opc == 7'b1100011 && f3[2:1] != 2'b01;
   assign is_ld    = opc == 7'b0000011 &&
                     (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                      f3 == 3'b100 || f3 == 3'b101);
   assign is_st    = opc == 7'b0100011 && !f3[2] && f3[1:0] != 2'b11;
   // Shift-immediates carry funct7; other OP-IMM encodings use it as imm.
   assign is_opi   = opc == 7'b0010011 &&
                     (f3 == 3'b001 ? f7 == 7'b0000000 :
                      f3 == 3'b101 ? (f7 == 7'b0000000 || f7 == 7'b0100000) :
                      1'b1);
   assign is_op    = opc == 7'b0110011 &&
                     (f7 == 7'b0000000 ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
   assign is_ecall  = inst == 32'h0000_0073;
   assign is_ebreak = inst == 32'h0010_0073;
   assign is_mret   = inst == 32'h3020_0073;
   assign is_csrrw  = opc == 7'b1110011 && f3 == 3'b001;
   assign is_csrrs  = opc == 7'b1110011 && f3 == 3'b010;

   assign legal = is_lui | is_auipc | is_jal | is_jalr | is_br |
                  is_ld | is_st | is_opi | is_op |
                  is_ecall | is_mret | is_csrrw | is_csrrs;
   assign en = ivalid && legal && !is_ebreak;

   always_comb begin
      imm = imm_i;
      unique case (1'b1)
         is_st:              imm = imm_s;
         is_br:              imm = imm_b;
         is_lui || is_auipc: imm = imm_u;
         is_jal:             imm = imm_j;
         default:            imm = imm_i;
      endcase
   end

   always_comb begin
      alu_op = ALU_ADD;
      if (is_op || is_opi) begin
         case (f3)
            3'b000: alu_op = (is_op && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
         endcase
      end
   end

   assign op2   = (is_op || is_br) ? src2 : imm;
   assign shamt = op2[4:0];

   always_comb begin
      alu_result = src1 + op2;
      case (alu_op)
         ALU_SUB:  alu_result = src1 - op2;
         ALU_SLL:  alu_result = src1 << shamt;
         ALU_SLT:  alu_result = {31'b0, $signed(src1) < $signed(op2)};
         ALU_SLTU: alu_result = {31'b0, src1 < op2};
         ALU_XOR:  alu_result = src1 ^ op2;
         ALU_SRL:  alu_result = src1 >> shamt;
         ALU_SRA:  alu_result = $signed(src1) >>> shamt;
         ALU_OR:   alu_result = src1 | op2;
         ALU_AND:  alu_result = src1 & op2;
         default:  alu_result = src1 + op2;
      endcase
   end

   always_comb begin
      br_take = 1'b0;
      case (f3)
         3'b000: br_take = src1 == src2;
         3'b001: br_take = src1 != src2;
         3'b100: br_take = $signed(src1) < $signed(src2);
         3'b101: br_take = $signed(src1) >= $signed(src2);
         3'b110: br_take = src1 < src2;
         3'b111: br_take = src1 >= src2;
         default: br_take = 1'b0;
      endcase
   end

   always_comb begin
      npc = pc4;
      unique case (1'b1)
         is_jal:              npc = pc + imm_j;
         is_jalr:             npc = {alu_result[31:1], 1'b0};
         is_br && br_take:    npc = pc + imm_b;
         is_ecall || is_mret: npc = csr_src;
         default:             npc = pc4;
      endcase
   end

   always_comb begin
      r_wdata = alu_result;
      unique case (1'b1)
         is_ld:                 r_wdata = mem_rdata;
         is_jal || is_jalr:     r_wdata = pc4;
         is_lui:                r_wdata = imm_u;
         is_auipc:              r_wdata = pc + imm_u;
         is_csrrw || is_csrrs:  r_wdata = csr_src;
         default:               r_wdata = alu_result;
      endcase
   end

   assign r_wen = en && rd != 5'd0 &&
                  (is_lui | is_auipc | is_jal | is_jalr | is_ld |
                   is_opi | is_op | is_csrrw | is_csrrs);
   assign mem_ren  = en && is_ld;
   assign mem_wen  = en && is_st;
   assign suffix_b = (is_ld || is_st) && f3[1:0] == 2'b00;
   assign suffix_h = (is_ld || is_st) && f3[1:0] == 2'b01;
   assign sext     = is_ld && !f3[2] && !f3[1];

   always_comb begin
      csr_s      = '0;
      csr_d1     = '0;
      csr_d2     = '0;
      csr_wen1   = 1'b0;
      csr_wen2   = 1'b0;
      csr_wdata1 = src1;
      csr_wdata2 = 32'd11;
      unique case (1'b1)
         is_csrrw: begin
            csr_s    = inst[31:20];
            csr_d1   = inst[31:20];
            csr_wen1 = en;
         end
         is_csrrs: begin
            csr_s      = inst[31:20];
            csr_d1     = inst[31:20];
            csr_wen1   = en;
            csr_wdata1 = csr_src | src1;
         end
         is_ecall: begin
            csr_s      = 12'h305;
            csr_d1     = 12'h341;
            csr_d2     = 12'h342;
            csr_wen1   = en;
            csr_wen2   = en;
            csr_wdata1 = pc;
         end
         is_mret: csr_s = 12'h341;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25010008_fetch_decode_exec.sv
// Directed bench for the fetch/decode/execute block.
// Each step fetches one instruction and checks hand-computed outputs.
module tb_ysyx_25010008_fetch_decode_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        fetch;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] src1, src2, csr_src, mem_rdata;
   logic [31:0] inst;
   logic        ivalid;
   logic [4:0]  rs1, rs2, rd;
   logic        r_wen;
   logic [31:0] r_wdata;
   logic [11:0] csr_s, csr_d1, csr_d2;
   logic        csr_wen1, csr_wen2;
   logic [31:0] csr_wdata1, csr_wdata2;
   logic        mem_ren, mem_wen;
   logic        suffix_b, suffix_h, sext;
   logic [31:0] alu_result;
   logic [31:0] npc;
   logic        halt;

   int n_vec = 0;
   int n_err = 0;

   ysyx_25010008_fetch_decode_exec dut (
      .clk(clk), .rst(rst), .pc(pc), .fetch(fetch),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .src1(src1), .src2(src2), .csr_src(csr_src),
      .mem_rdata(mem_rdata), .inst(inst), .ivalid(ivalid),
      .rs1(rs1), .rs2(rs2), .rd(rd), .r_wen(r_wen),
      .r_wdata(r_wdata), .csr_s(csr_s), .csr_d1(csr_d1),
      .csr_d2(csr_d2), .csr_wen1(csr_wen1), .csr_wen2(csr_wen2),
      .csr_wdata1(csr_wdata1), .csr_wdata2(csr_wdata2),
      .mem_ren(mem_ren), .mem_wen(mem_wen),
      .suffix_b(suffix_b), .suffix_h(suffix_h), .sext(sext),
      .alu_result(alu_result), .npc(npc), .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_fetch(input logic [31:0] p, input logic [31:0] i);
      pc         = p;
      imem_rdata = i;
      fetch      = 1'b1;
      @(posedge clk);
      #1;
      fetch      = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   initial begin
      rst = 1'b1; fetch = 1'b1; pc = 32'h8000_0000;
      imem_rdata = 32'h0050_0093;
      src1 = '0; src2 = '0; csr_src = '0; mem_rdata = '0;
      @(posedge clk);
      #2;
      chk("rst_inst", inst, 32'h0);
      chk("rst_ivalid", {31'b0, ivalid}, 32'd0);
      chk("rst_halt", {31'b0, halt}, 32'd0);
      chk("rst_rwen", {31'b0, r_wen}, 32'd0);
      chk("rst_memen", {30'b0, mem_ren, mem_wen}, 32'd0);
      chk("rst_csrwen", {30'b0, csr_wen1, csr_wen2}, 32'd0);
      fetch = 1'b0;
      rst   = 1'b0;

      // addi x1,x0,5
      do_fetch(32'h8000_0000, 32'h0050_0093);
      chk("addi_ivalid", {31'b0, ivalid}, 32'd1);
      chk("addi_inst", inst, 32'h0050_0093);
      chk("addi_imem_addr", imem_addr, 32'h8000_0000);
      chk("addi_rd", {27'b0, rd}, 32'd1);
      chk("addi_rwen", {31'b0, r_wen}, 32'd1);
      chk("addi_wdata", r_wdata, 32'd5);
      chk("addi_npc", npc, 32'h8000_0004);

      // sub x3,x1,x2
      src1 = 32'd10; src2 = 32'd3;
      do_fetch(32'h8000_0004, 32'h4020_81B3);
      chk("sub_rs", {22'b0, rs1, rs2}, {22'b0, 5'd1, 5'd2});
      chk("sub_alu", alu_result, 32'd7);
      chk("sub_wdata", r_wdata, 32'd7);
      chk("sub_rwen", {31'b0, r_wen}, 32'd1);

      // beq x1,x2,-8
      src1 = 32'd7; src2 = 32'd7;
      do_fetch(32'h8000_0020, 32'hFE20_8CE3);
      chk("beq_taken_npc", npc, 32'h8000_0018);
      chk("beq_rwen", {31'b0, r_wen}, 32'd0);
      src2 = 32'd8;
      #1;
      chk("beq_fall_npc", npc, 32'h8000_0024);

      // jalr x1,0(x5)
      src1 = 32'h8000_0013;
      do_fetch(32'h8000_0040, 32'h0002_80E7);
      chk("jalr_npc", npc, 32'h8000_0012);
      chk("jalr_wdata", r_wdata, 32'h8000_0044);
      chk("jalr_rwen", {31'b0, r_wen}, 32'd1);

      // lui x5,0x12345 ; auipc x6,1
      do_fetch(32'h8000_0050, 32'h1234_52B7);
      chk("lui_wdata", r_wdata, 32'h1234_5000);
      chk("lui_npc", npc, 32'h8000_0054);
      do_fetch(32'h8000_0100, 32'h0000_1317);
      chk("auipc_wdata", r_wdata, 32'h8000_1100);

      // lbu x7,3(x8)
      src1 = 32'h8000_1000; mem_rdata = 32'h0000_00AB;
      do_fetch(32'h8000_0104, 32'h0034_4383);
      chk("lbu_addr", alu_result, 32'h8000_1003);
      chk("lbu_ren", {31'b0, mem_ren}, 32'd1);
      chk("lbu_wen", {31'b0, mem_wen}, 32'd0);
      chk("lbu_size", {30'b0, suffix_b, suffix_h}, 32'd2);
      chk("lbu_sext", {31'b0, sext}, 32'd0);
      chk("lbu_wdata", r_wdata, 32'h0000_00AB);

      // sw x2,8(x1)
      src1 = 32'h8000_2000; src2 = 32'h1111_2222;
      do_fetch(32'h8000_0108, 32'h0020_A423);
      chk("sw_addr", alu_result, 32'h8000_2008);
      chk("sw_en", {29'b0, mem_wen, mem_ren, r_wen}, 32'd4);
      chk("sw_size", {30'b0, suffix_b, suffix_h}, 32'd0);

      // addi x0,x0,1 must not write
      do_fetch(32'h8000_010C, 32'h0010_0013);
      chk("x0_rwen", {31'b0, r_wen}, 32'd0);

      // ecall
      csr_src = 32'h8000_0100;
      do_fetch(32'h8000_0010, 32'h0000_0073);
      chk("ecall_npc", npc, 32'h8000_0100);
      chk("ecall_csr_s", {20'b0, csr_s}, 32'h305);
      chk("ecall_d1", {20'b0, csr_d1}, 32'h341);
      chk("ecall_d2", {20'b0, csr_d2}, 32'h342);
      chk("ecall_wdata1", csr_wdata1, 32'h8000_0010);
      chk("ecall_wdata2", csr_wdata2, 32'd11);
      chk("ecall_wen", {30'b0, csr_wen1, csr_wen2}, 32'd3);
      chk("ecall_rwen", {31'b0, r_wen}, 32'd0);

      // csrrs x10,0x300,x11
      csr_src = 32'h0000_00F0; src1 = 32'h0000_000F;
      do_fetch(32'h8000_0014, 32'h3005_A573);
      chk("csrrs_wdata1", csr_wdata1, 32'h0000_00FF);
      chk("csrrs_rwdata", r_wdata, 32'h0000_00F0);
      chk("csrrs_idx", {8'b0, csr_s, csr_d1}, {8'b0, 12'h300, 12'h300});
      chk("csrrs_wen", {30'b0, csr_wen1, csr_wen2}, 32'd2);

      // ebreak: no side effects, halt after next edge, sticky
      do_fetch(32'h8000_0200, 32'h0010_0073);
      chk("ebreak_halt_pre", {31'b0, halt}, 32'd0);
      chk("ebreak_en", {28'b0, r_wen, mem_wen, csr_wen1, csr_wen2}, 32'd0);
      @(posedge clk);
      #1;
      chk("ebreak_halt", {31'b0, halt}, 32'd1);
      do_fetch(32'h8000_0204, 32'h0050_0093);
      chk("halt_sticky", {31'b0, halt}, 32'd1);
      chk("post_halt_rwen", {31'b0, r_wen}, 32'd1);

      // async reset between edges
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ivalid", {31'b0, ivalid}, 32'd0);
      chk("arst_halt", {31'b0, halt}, 32'd0);
      chk("arst_rwen", {31'b0, r_wen}, 32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_hold", {30'b0, ivalid, r_wen}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
